// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MIPS-style HI/LO multiply/divide unit
// Result is computed at the accepted start edge and held pending until the busy period expires.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        occupy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] phi_q, phi_d, plo_q, plo_d;

    logic        sx_a, sx_b, neg_a, neg_b, b_zero;
    logic [63:0] prod;
    logic [31:0] ua, ub, q_u, r_u, quot, rem;
    logic [31:0] res_hi, res_lo;

    // Signed divide works on magnitudes so that 0x80000000 / -1 wraps to 0x80000000.
    always_comb begin
        sx_a   = a[31] & ~op[0];
        sx_b   = b[31] & ~op[0];
        prod   = {{32{sx_a}}, a} * {{32{sx_b}}, b};
        neg_a  = sx_a;
        neg_b  = sx_b;
        b_zero = (b == 32'd0);
        ua     = neg_a ? (32'd0 - a) : a;
        ub     = b_zero ? 32'd1 : (neg_b ? (32'd0 - b) : b);
        q_u    = ua / ub;
        r_u    = ua % ub;
        quot   = (neg_a ^ neg_b) ? (32'd0 - q_u) : q_u;
        rem    = neg_a ? (32'd0 - r_u) : r_u;
        if (op[1]) begin
            // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
            res_hi = b_zero ? hi_q : rem;
            res_lo = b_zero ? lo_q : quot;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    phi_d   = res_hi;
                    plo_d   = res_lo;
                    cnt_d   = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            RUN: begin
                if (cnt_q == 4'd1) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign busy   = busy_q;
    assign occupy = busy_q | start;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized and directed bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy, occupy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .occupy(occupy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {HI, LO}; divide by zero is handled by the caller.
    function automatic logic [63:0] model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, p;
        case (o)
            2'd0: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = 64'(sx * sy);
                return p;
            end
            2'd1: begin
                ux = {32'd0, x};
                uy = {32'd0, y};
                return ux * uy;
            end
            2'd2: begin
                if (y == 0) return 64'd0;
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                q  = sx / sy;
                r  = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return 64'd0;
                return {x % y, x / y};
            end
        endcase
    endfunction

    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_skip;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_hi   <= 0;
            m_lo   <= 0;
            p_hi   <= 0;
            p_lo   <= 0;
            p_skip <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && !p_skip) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (start) begin
            {p_hi, p_lo} <= model_op(op, a, b);
            p_skip <= op[1] && (b == 0);
            m_left <= op[1] ? 10 : 5;
        end else begin
            if (mthi) m_hi <= wdata;
            if (mtlo) m_lo <= wdata;
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_left != 0));
        chk("occupy", 64'(occupy), 64'((m_left != 0) | start));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Operands are scrambled right after the start edge to show they are sampled only there.
    task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input string nm, input logic [31:0] old_hi, input logic [31:0] old_lo, output int n);
        n = 0;
        while (busy && n < 40) begin
            chk({nm, "_hold_hi"}, 64'(hi), 64'(old_hi));
            chk({nm, "_hold_lo"}, 64'(lo), 64'(old_lo));
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        chk("model_mult", model_op(2'd0, 32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
        chk("model_multu", model_op(2'd1, 32'hFFFFFFFF, 32'd2), 64'h00000001_FFFFFFFE);
        chk("model_div", model_op(2'd2, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        chk("model_div_ovf", model_op(2'd2, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
        chk("model_divu", model_op(2'd3, 32'd100, 32'd7), 64'h00000002_0000000E);

        step(); step();
        reset = 1'b1;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_occupy", 64'(occupy), 64'd0);

        go(2'd0, 32'hFFFFFFFD, 32'd5);
        wait_done("mult", 32'd0, 32'd0, n);
        chk("mult_cycles", 64'(n), 64'd5);
        chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_lo", 64'(lo), 64'hFFFFFFF1);

        go(2'd1, 32'hFFFFFFFF, 32'd2);
        wait_done("multu", 32'hFFFFFFFF, 32'hFFFFFFF1, n);
        chk("multu_cycles", 64'(n), 64'd5);
        chk("multu_hi", 64'(hi), 64'h1);
        chk("multu_lo", 64'(lo), 64'hFFFFFFFE);

        go(2'd2, 32'hFFFFFFF9, 32'd2);
        wait_done("div", 32'h1, 32'hFFFFFFFE, n);
        chk("div_cycles", 64'(n), 64'd10);
        chk("div_hi", 64'(hi), 64'hFFFFFFFF);
        chk("div_lo", 64'(lo), 64'hFFFFFFFD);

        go(2'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", 32'hFFFFFFFF, 32'hFFFFFFFD, n);
        chk("div_ovf_hi", 64'(hi), 64'h0);
        chk("div_ovf_lo", 64'(lo), 64'h80000000);

        mthi = 1'b1; wdata = 32'h11; step(); mthi = 1'b0;
        mtlo = 1'b1; wdata = 32'h22; step(); mtlo = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h11);
        chk("mtlo_lo", 64'(lo), 64'h22);
        go(2'd3, 32'd7, 32'd0);
        wait_done("divu0", 32'h11, 32'h22, n);
        chk("divu0_cycles", 64'(n), 64'd10);
        chk("divu0_hi", 64'(hi), 64'h11);
        chk("divu0_lo", 64'(lo), 64'h22);

        go(2'd3, 32'd100, 32'd7);
        n = 1;
        for (int c = 1; c < 40 && busy; c++) begin
            if (c == 3) begin start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3; end
            if (c == 4) begin mthi = 1'b1; wdata = 32'hAA; end
            if (c == 3) chk("run_start_occupy", 64'(occupy), 64'd1);
            step();
            start = 1'b0; mthi = 1'b0;
            if (busy) n++;
        end
        chk("ignore_cycles", 64'(n), 64'd10);
        chk("ignore_hi", 64'(hi), 64'd2);
        chk("ignore_lo", 64'(lo), 64'd14);

        go(2'd0, 32'd4, 32'd4);
        step();
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        #1 reset = 1'b1;
        step();
        go(2'd1, 32'd4, 32'd4);
        wait_done("post_rst", 32'd0, 32'd0, n);
        chk("post_rst_cycles", 64'(n), 64'd5);
        chk("post_rst_lo", 64'(lo), 64'd16);

        start = 1'b1; op = 2'd0; a = 32'd1; b = 32'd1; mtlo = 1'b1; wdata = 32'h55;
        #1;
        chk("both_occupy", 64'(occupy), 64'd1);
        chk("both_busy", 64'(busy), 64'd0);
        step();
        start = 1'b0; mtlo = 1'b0;
        wait_done("both", 32'd0, 32'd16, n);
        chk("both_hi", 64'(hi), 64'd0);
        chk("both_lo", 64'(lo), 64'd1);

        for (int i = 0; i < 4000; i++) begin
            logic [31:0] sp [6];
            sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFFFFFF;
            sp[3] = 32'h80000000; sp[4] = 32'h7FFFFFFF; sp[5] = $urandom;
            start = ($urandom_range(3) == 0);
            op    = 2'($urandom);
            a     = ($urandom_range(3) == 0) ? sp[$urandom_range(5)] : $urandom;
            b     = ($urandom_range(3) == 0) ? sp[$urandom_range(5)] : $urandom;
            mthi  = ($urandom_range(7) == 0);
            mtlo  = ($urandom_range(7) == 0);
            wdata = $urandom;
            if ($urandom_range(499) == 0) begin
                reset = 1'b0;
                #1 reset = 1'b1;
            end
            step();
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
